// File: rtl/ext_mem_responder.sv
// ext_mem_responder: word-addressed memory model answering a valid/ready style
// read and write handshake with fixed, parameterised response latency.
//
// Ports
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   wvalid/waddr/wdata : write request, held by the initiator until wready
//   wready             : one-cycle write acknowledge
//   rvalid/raddr       : read request, held by the initiator until rready
//   rready/rdata       : one-cycle read response; rdata holds between responses
//   err                : sticky out-of-range flag, cleared only by rst
//   rd_cnt/wr_cnt      : completed read/write counters, wrapping at 16 bits
module ext_mem_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned READ_LAT  = 2,
  parameter int unsigned WRITE_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [25:0] waddr,
  input  logic [31:0] wdata,
  input  logic        rvalid,
  output logic        rready,
  input  logic [25:0] raddr,
  output logic [31:0] rdata,
  output logic        err,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned LAT_W   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CNT_W   = 16;
  localparam logic [DATA_W-1:0] OOR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_RESP = 3'd2,
    WR_WAIT = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q,   state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              last_wr_q, last_wr_d;
  logic [DATA_W-1:0] rbuf_q,    rbuf_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              rready_q,  rready_d;
  logic              wready_q,  wready_d;
  logic              err_q,     err_d;
  logic [CNT_W-1:0]  rd_cnt_q,  rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q,  wr_cnt_d;

  logic              serve_wr_c;
  logic              mem_we_c;
  logic              r_oor_c;
  logic              w_oor_c;
  logic [DATA_W-1:0] mem_rdata_c;

  // Any address bit at or above ADDR_W marks the access as out of range.
  assign r_oor_c     = (raddr >> ADDR_W) != 26'd0;
  assign w_oor_c     = (waddr >> ADDR_W) != 26'd0;
  assign mem_rdata_c = mem[raddr[ADDR_W-1:0]];

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    last_wr_d  = last_wr_q;
    rbuf_d     = rbuf_q;
    err_d      = err_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    serve_wr_c = 1'b0;
    mem_we_c   = 1'b0;

    case (state_q)
      IDLE: begin
        // On a collision the winner alternates; last_wr only tracks contested
        // arbitrations so an uncontested follow-up does not flip priority.
        serve_wr_c = wvalid && (!rvalid || !last_wr_q);
        if (rvalid && wvalid) begin
          last_wr_d = serve_wr_c;
        end
        if (serve_wr_c) begin
          // The array is updated at the capture edge; out-of-range data is dropped.
          mem_we_c  = !w_oor_c && !rst;
          err_d     = err_q | w_oor_c;
          lat_cnt_d = LAT_W'(WRITE_LAT - 1);
          state_d   = (WRITE_LAT == 1) ? WR_RESP : WR_WAIT;
        end else if (rvalid) begin
          rbuf_d    = r_oor_c ? OOR_DATA : mem_rdata_c;
          err_d     = err_q | r_oor_c;
          lat_cnt_d = LAT_W'(READ_LAT - 1);
          state_d   = (READ_LAT == 1) ? RD_RESP : RD_WAIT;
        end
      end
      RD_WAIT: begin
        lat_cnt_d = LAT_W'(lat_cnt_q - LAT_W'(1));
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = RD_RESP;
        end
      end
      WR_WAIT: begin
        lat_cnt_d = LAT_W'(lat_cnt_q - LAT_W'(1));
        if (lat_cnt_q == LAT_W'(1)) begin
          state_d = WR_RESP;
        end
      end
      RD_RESP: begin
        rd_cnt_d = CNT_W'(rd_cnt_q + CNT_W'(1));
        state_d  = IDLE;
      end
      WR_RESP: begin
        wr_cnt_d = CNT_W'(wr_cnt_q + CNT_W'(1));
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Acks are registered: they rise on the edge that enters the response state.
    rready_d = (state_d == RD_RESP);
    wready_d = (state_d == WR_RESP);
    rdata_d  = (state_d == RD_RESP) ? rbuf_d : rdata_q;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      last_wr_q <= 1'b0;
      rbuf_q    <= '0;
      rdata_q   <= '0;
      rready_q  <= 1'b0;
      wready_q  <= 1'b0;
      err_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      last_wr_q <= last_wr_d;
      rbuf_q    <= rbuf_d;
      rdata_q   <= rdata_d;
      rready_q  <= rready_d;
      wready_q  <= wready_d;
      err_q     <= err_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Storage array; deliberately not reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[waddr[ADDR_W-1:0]] <= wdata;
    end
  end

  assign rready = rready_q;
  assign wready = wready_q;
  assign rdata  = rdata_q;
  assign err    = err_q;
  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_ext_mem_responder.sv
// tb_ext_mem_responder: directed checks of ext_mem_responder at default
// parameters (ADDR_W=12, READ_LAT=2, WRITE_LAT=1).
module tb_ext_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wvalid;
  logic        wready;
  logic [25:0] waddr;
  logic [31:0] wdata;
  logic        rvalid;
  logic        rready;
  logic [25:0] raddr;
  logic [31:0] rdata;
  logic        err;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  int n_tot = 0;
  int n_bad = 0;

  ext_mem_responder #(
    .ADDR_W   (12),
    .READ_LAT (2),
    .WRITE_LAT(1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .wvalid(wvalid),
    .wready(wready),
    .waddr (waddr),
    .wdata (wdata),
    .rvalid(rvalid),
    .rready(rready),
    .raddr (raddr),
    .rdata (rdata),
    .err   (err),
    .rd_cnt(rd_cnt),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; lat counts negedges from raising valid to seeing the ack
  // (capture edge is the first edge, so WRITE_LAT=1 gives 2, READ_LAT=2 gives 3).
  task automatic xact(input bit is_wr, input logic [25:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    rd   = '0;
    @(posedge clk); #1;
    if (is_wr) begin
      wvalid = 1'b1; waddr = a; wdata = d;
    end else begin
      rvalid = 1'b1; raddr = a;
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (is_wr ? wready : rready) begin
        seen = 1'b1;
        rd   = rdata;
        check(is_wr ? "wr_excl" : "rd_excl", 32'(is_wr ? rready : wready), 32'd0);
      end
    end
    if (!seen) check(is_wr ? "wr_timeout" : "rd_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    rvalid = 1'b0;
    @(negedge clk);
    check(is_wr ? "wr_pulse" : "rd_pulse", 32'({wready, rready}), 32'd0);
  endtask

  // Both valids raised together; reports which ack came first and the read data.
  task automatic collide(input logic [25:0] a, input logic [31:0] d,
                         output bit wr_first, output logic [31:0] rd);
    bit seen;
    wr_first = 1'b0;
    rd       = '0;
    @(posedge clk); #1;
    wvalid = 1'b1; waddr = a; wdata = d;
    rvalid = 1'b1; raddr = a;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wready || rready) begin
        seen     = 1'b1;
        wr_first = wready;
        if (rready) rd = rdata;
        check("col_excl", 32'(wready & rready), 32'd0);
      end
    end
    if (!seen) check("col_timeout1", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (wr_first) wvalid = 1'b0; else rvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (wr_first ? rready : wready) begin
        seen = 1'b1;
        if (wr_first) rd = rdata;
      end
    end
    if (!seen) check("col_timeout2", 32'd0, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    rvalid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          cyc;
    int          last;
    bit          seen;
    bit          wr_first;
    bit          any_ack;
    logic [31:0] rd;

    rst = 1'b1; wvalid = 1'b0; rvalid = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rready", 32'(rready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rdata",  rdata, 32'd0);
    check("rst_err",    32'(err), 32'd0);
    check("rst_rdcnt",  32'(rd_cnt), 32'd0);
    check("rst_wrcnt",  32'(wr_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic write then read.
    xact(1'b1, 26'd5, 32'h1234_5678, lat, rd);
    check("wr_lat", 32'(lat), 32'd2);
    xact(1'b0, 26'd5, 32'd0, lat, rd);
    check("rd_lat",   32'(lat), 32'd3);
    check("rd_data5", rd, 32'h1234_5678);
    check("cnt_rd1",  32'(rd_cnt), 32'd1);
    check("cnt_wr1",  32'(wr_cnt), 32'd1);

    // Preload 0..3, then stream reads with rvalid held high.
    for (int i = 0; i < 4; i++) xact(1'b1, 26'(i), 32'h1111_1111 * 32'(i + 1), lat, rd);
    @(posedge clk); #1;
    rvalid = 1'b1; raddr = 26'd0;
    cyc  = 0;
    last = 0;
    for (int i = 0; i < 4; i++) begin
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        cyc++;
        if (rready) begin
          seen = 1'b1;
          check("stream_data", rdata, 32'h1111_1111 * 32'(i + 1));
          check("stream_gap", 32'(cyc - last), 32'd3);
          last = cyc;
        end
      end
      if (!seen) check("stream_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (i < 3) raddr = 26'(i + 1); else rvalid = 1'b0;
    end
    @(negedge clk);
    check("cnt_rd5", 32'(rd_cnt), 32'd5);
    check("cnt_wr5", 32'(wr_cnt), 32'd5);

    // Collision arbitration after a fresh reset.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    collide(26'd9, 32'hCAFE_0001, wr_first, rd);
    check("col1_wr_first", 32'(wr_first), 32'd1);
    check("col1_rdata",    rd, 32'hCAFE_0001);
    collide(26'd9, 32'hCAFE_0002, wr_first, rd);
    check("col2_wr_first", 32'(wr_first), 32'd0);
    check("col2_rdata",    rd, 32'hCAFE_0001);
    xact(1'b0, 26'd9, 32'd0, lat, rd);
    check("col_after", rd, 32'hCAFE_0002);
    check("col_rdcnt", 32'(rd_cnt), 32'd3);
    check("col_wrcnt", 32'(wr_cnt), 32'd2);

    // Out-of-range accesses.
    check("err_clear", 32'(err), 32'd0);
    xact(1'b0, 26'h1000, 32'd0, lat, rd);
    check("oor_rdata", rd, 32'hDEAD_BEEF);
    check("oor_rd_lat", 32'(lat), 32'd3);
    check("oor_err",   32'(err), 32'd1);
    xact(1'b1, 26'h1005, 32'h0000_0BAD, lat, rd);
    check("oor_wr_lat", 32'(lat), 32'd2);
    xact(1'b0, 26'd5, 32'd0, lat, rd);
    check("oor_no_alias", rd, 32'h1234_5678);
    xact(1'b1, 26'd7, 32'h0000_0077, lat, rd);
    check("inr_wr_lat", 32'(lat), 32'd2);
    check("err_sticky", 32'(err), 32'd1);
    check("oor_rdcnt", 32'(rd_cnt), 32'd5);
    check("oor_wrcnt", 32'(wr_cnt), 32'd4);

    // Reset while waiting on read latency.
    @(posedge clk); #1;
    rvalid = 1'b1; raddr = 26'd9;
    @(posedge clk); #2;
    rvalid = 1'b0;
    rst    = 1'b1;
    #1;
    check("mid_rready", 32'(rready), 32'd0);
    check("mid_wready", 32'(wready), 32'd0);
    check("mid_rdata",  rdata, 32'd0);
    check("mid_err",    32'(err), 32'd0);
    check("mid_rdcnt",  32'(rd_cnt), 32'd0);
    check("mid_wrcnt",  32'(wr_cnt), 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_ack = any_ack | rready | wready;
    end
    check("mid_no_ack", 32'(any_ack), 32'd0);
    xact(1'b0, 26'd9, 32'd0, lat, rd);
    check("mem_kept", rd, 32'hCAFE_0002);
    check("mid_rdcnt1", 32'(rd_cnt), 32'd1);

    // Write counter wrap, starting just below the top.
    @(negedge clk);
    force dut.wr_cnt_q = 16'hFFFE;
    #1;
    release dut.wr_cnt_q;
    xact(1'b1, 26'd11, 32'h0000_0011, lat, rd);
    check("wrap_ffff", 32'(wr_cnt), 32'h0000_FFFF);
    xact(1'b1, 26'd12, 32'h0000_0012, lat, rd);
    check("wrap_zero", 32'(wr_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
